// File: rtl/booth_sequencer_pkg.sv
// booth_sequencer_pkg: FSM/op encodings and default widths for the radix-2 Booth sequencer
package booth_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {NOP, ADD, SUB} op_t;
    localparam int DEF_WIDTH_IN = 16;
    localparam int DEF_WIDTH_PP = 2*DEF_WIDTH_IN+1;
endpackage

// File: rtl/booth_sequencer_if.sv
// booth_sequencer_if: start/result handshake bundle between requester and sequencer
interface booth_sequencer_if #(parameter int WIDTH_IN = 16);
    logic                  start_i;
    logic                  ready_o;
    logic [WIDTH_IN-1:0]   multiplicand_i;
    logic                  valid_o;
    logic                  result_ready_i;
    logic [2*WIDTH_IN-1:0] result_o;
    modport master(output start_i, multiplicand_i, result_ready_i, input ready_o, valid_o, result_o);
    modport slave(input start_i, multiplicand_i, result_ready_i, output ready_o, valid_o, result_o);
endinterface

// File: rtl/booth_sequencer_step.sv
// booth_step: one Booth iteration - op decode, WIDTH_IN+1 add/sub, arithmetic shift right
module booth_step
    import booth_sequencer_pkg::*;
#(
    parameter int WIDTH_IN = DEF_WIDTH_IN,
    parameter int WIDTH_PP = 2*WIDTH_IN+1
) (
    input  logic [WIDTH_PP-1:0] pp_i,
    input  logic [WIDTH_IN-1:0] m_i,
    output logic [WIDTH_PP-1:0] pp_next_o
);
    op_t               op;
    logic [WIDTH_IN:0] a, mx, s;
    assign op = pp_i[1:0] == 2'b01 ? ADD : pp_i[1:0] == 2'b10 ? SUB : NOP;
    assign a  = {pp_i[WIDTH_PP-1], pp_i[WIDTH_PP-1 -: WIDTH_IN]};
    assign mx = {m_i[WIDTH_IN-1], m_i};
    assign s  = op == ADD ? a + mx : op == SUB ? a - mx : a;
    // Extra sum bit keeps the shifted-in sign right even for M = -2^(WIDTH_IN-1)
    assign pp_next_o = {s, pp_i[WIDTH_IN:1]};
endmodule

// File: rtl/booth_sequencer.sv
// booth_sequencer: FSM, counter, M register and handshake for a sequential Booth multiplier.
// Define BOOTH_ABORT_EN to add abort_i, which returns RUN/DONE to IDLE without a result.
module booth_sequencer
    import booth_sequencer_pkg::*;
#(
    parameter int WIDTH_IN = DEF_WIDTH_IN,
    parameter int WIDTH_PP = 2*WIDTH_IN+1
) (
    input  logic                clk,
    input  logic                reset,
    booth_sequencer_if.slave    bus,
`ifdef BOOTH_ABORT_EN
    input  logic                abort_i,
`endif
    output logic                load_o,
    input  logic [WIDTH_PP-1:0] pp_q_i,
    output logic [WIDTH_PP-1:0] pp_next_o
);
    localparam int CNT_W = $clog2(WIDTH_IN)+1;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH_IN-1:0] m_q, m_d;
    logic [WIDTH_PP-1:0] step_next;
    logic                accept, abort;
`ifdef BOOTH_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif
    booth_step #(.WIDTH_IN(WIDTH_IN), .WIDTH_PP(WIDTH_PP)) u_step (
        .pp_i(pp_q_i), .m_i(m_q), .pp_next_o(step_next)
    );
    assign accept         = state_q == IDLE && bus.start_i;
    assign load_o         = accept;
    assign bus.ready_o    = state_q == IDLE;
    assign bus.valid_o    = state_q == DONE;
    assign bus.result_o   = pp_q_i[WIDTH_PP-1:1];
    assign pp_next_o      = state_q == RUN ? step_next : pp_q_i;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            m_d     = bus.multiplicand_i;
        end else if (state_q == RUN) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = cnt_q == CNT_W'(WIDTH_IN-1) ? DONE : RUN;
        end else if (state_q == DONE && bus.result_ready_i) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
        end
    end
endmodule

// File: tb/tb_booth_sequencer.sv
// tb_booth_sequencer: random and directed products against a plain signed-multiply model
module tb_booth_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load;
    logic [32:0] pp = '0;
    logic [32:0] pp_next;
    logic [15:0] b_op = '0;
    int          checks = 0;
    int          failures = 0;
    booth_sequencer_if #(.WIDTH_IN(16)) bus();
`ifdef BOOTH_ABORT_EN
    logic abort = 1'b0;
`endif
    booth_sequencer #(.WIDTH_IN(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
`ifdef BOOTH_ABORT_EN
        .abort_i(abort),
`endif
        .load_o(load), .pp_q_i(pp), .pp_next_o(pp_next)
    );
    always #5 clk = ~clk;
    // External partial-product register: loads {0,B,0} when asked, else follows pp_next
    always @(posedge clk) pp <= load ? {16'b0, b_op, 1'b0} : pp_next;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_prod(input logic [15:0] m, input logic [15:0] b);
        longint p = longint'($signed(m)) * longint'($signed(b));
        return p[31:0];
    endfunction

    task automatic run_op(input logic [15:0] m, input logic [15:0] b, input bit noisy, input int hold);
        int n = 0;
        logic [31:0] exp = ref_prod(m, b);
        @(negedge clk);
        check("ready_before", bus.ready_o, 1);
        bus.multiplicand_i = m;
        b_op = b;
        bus.start_i = 1'b1;
        do begin
            @(negedge clk);
            n++;
            bus.start_i = noisy;
            bus.multiplicand_i = noisy ? 16'($urandom) : m;
            if (noisy) b_op = 16'($urandom);
        end while (!bus.valid_o && n < 40);
        check("latency", 64'(n), 17);
        check("result", bus.result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", bus.valid_o, 1);
            check("hold_result", bus.result_o, exp);
        end
        bus.result_ready_i = 1'b1;
        @(negedge clk);
        bus.result_ready_i = 1'b0;
        bus.start_i = 1'b0;
        check("take_ready", bus.ready_o, 1);
        check("take_valid", bus.valid_o, 0);
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.multiplicand_i = '0;
        bus.result_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.ready_o, 1);
        check("rst_valid", bus.valid_o, 0);
        check("rst_load", load, 0);
        reset = 1'b1;
        run_op(16'd3, 16'd5, 0, 0);
        run_op(-16'sd7, 16'd6, 0, 1);
        run_op(16'd32767, -16'sd1, 0, 0);
        run_op(16'h8000, 16'h8000, 0, 2);
        run_op(16'h8000, 16'd1, 0, 0);
        run_op(16'd1234, -16'sd321, 1, 5);
        @(negedge clk);
        bus.multiplicand_i = 16'd777;
        b_op = 16'd555;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_ready", bus.ready_o, 1);
        check("mid_rst_valid", bus.valid_o, 0);
        check("mid_rst_load", load, 0);
        @(negedge clk);
        reset = 1'b1;
        run_op(16'd100, -16'sd3, 0, 0);
`ifdef BOOTH_ABORT_EN
        @(negedge clk);
        bus.multiplicand_i = 16'd99;
        b_op = 16'd99;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ready", bus.ready_o, 1);
        check("abort_valid", bus.valid_o, 0);
        run_op(16'd2, 16'd2, 0, 0);
`endif
        for (int i = 0; i < 20; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
